// File: rtl/cpu_axi_bridge_if.sv
// Bundles the CPU-side SRAM-like request ports and the AXI channels used by
// the bridge. The master modport is the bridge's view; slave is the environment.
interface cpu_axi_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awid, awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awid, awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Bridges separate instruction/data CPU request ports onto a single AXI master
// with at most one transaction in flight; data requests win over instruction.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input logic              clk,
  input logic              resetn,
  cpu_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        owner_data_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        inst_ok_q;
  logic        data_ok_q;

  logic        accept_data;
  logic        accept_inst;
  logic        aw_hs;
  logic        w_hs;

  // Acceptance is gated by resetn so addr_ok stays low while reset is held.
  assign accept_data = resetn && (state == IDLE) && bus.data_req;
  assign accept_inst = resetn && (state == IDLE) && bus.inst_req && !bus.data_req;
  assign aw_hs       = (state == AW_W) && !aw_done && bus.awready;
  assign w_hs        = (state == AW_W) && !w_done && bus.wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state       = state;
    bus.arvalid      = 1'b0;
    bus.rready       = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;
    bus.data_addr_ok = accept_data;
    bus.inst_addr_ok = accept_inst;
    unique case (state)
      IDLE: begin
        if (accept_data)      next_state = bus.data_wr ? AW_W : AR;
        else if (accept_inst) next_state = AR;
      end
      AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) next_state = R;
      end
      R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) next_state = IDLE;
      end
      AW_W: begin
        bus.awvalid = !aw_done;
        bus.wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = B;
      end
      B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture; the read/write decision lives in the state itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      owner_data_q <= 1'b0;
    end else if (accept_data) begin
      addr_q       <= bus.data_addr;
      wdata_q      <= bus.data_wdata;
      wstrb_q      <= bus.data_wstrb;
      owner_data_q <= 1'b1;
    end else if (accept_inst) begin
      addr_q       <= bus.inst_addr;
      owner_data_q <= 1'b0;
    end
  end

  // Write-channel progress; AW and W may complete in either order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Response capture and one-cycle data_ok pulses for the transaction owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      if ((state == R) && bus.rvalid) begin
        if (owner_data_q) begin
          data_rdata_q <= bus.rdata;
          data_ok_q    <= 1'b1;
        end else begin
          inst_rdata_q <= bus.rdata;
          inst_ok_q    <= 1'b1;
        end
      end
      if ((state == B) && bus.bvalid) data_ok_q <= 1'b1;
    end
  end

  assign bus.arid         = owner_data_q ? DATA_ID : INST_ID;
  assign bus.araddr       = addr_q;
  assign bus.awid         = DATA_ID;
  assign bus.awaddr       = addr_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;
  assign bus.inst_data_ok = inst_ok_q;
  assign bus.data_data_ok = data_ok_q;

endmodule
